dense2_argmax: RTL and testbench
================================

Name: dense2_argmax

Overview:
Second fully-connected layer and classifier, directly downstream of the 120-neuron dense-1/sigmoid stage.
- Consumes that stage's serial frame of N_IN signed fixed-point activations.
- Runs N_OUT neuron MACs in parallel against a shared wide weight ROM, then adds biases and saturates.
- Emits the N_OUT logits serially with frame markers, followed by the argmax class index.

Parameters:
N_IN, 120, activations per frame (input vector length)
N_OUT, 10, output neurons/classes
DW, 16, signed data width of activations, weights, biases and logits
FRAC_BITS, 8, fractional bits of the fixed-point format (1.0 = 0x0100)
ACC_W, 32, signed accumulator width
AW, 7, ROM address width; must satisfy 2^AW > N_IN

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  dense_input carries a sample this cycle
frame_start_in  in  1  qualifies the first sample of a frame (with in_valid)
frame_end_in  in  1  qualifies the last sample of a frame (with in_valid)
dense_input  in  DW  signed activation
rom_en  out  1  ROM read enable
rom_addr  out  AW  ROM address; 0..N_IN-1 are weight rows, N_IN is the bias row
rom_data  in  N_OUT*DW  ROM row, 1-cycle read latency; neuron k at bits [k*DW+DW-1:k*DW]
out_valid  out  1  logit_out valid
frame_start_out  out  1  with first logit
frame_end_out  out  1  with last logit
logit_out  out  DW  signed logit, neuron order 0..N_OUT-1
class_valid  out  1  one-cycle pulse
class_idx  out  4  argmax index, valid with class_valid
err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset: all outputs 0; FSM to IDLE; sample counter, accumulators and argmax registers cleared. Reset during any state aborts the frame and emits no partial output.
- FSM states: IDLE, ACCUM, BIAS_RD, BIAS_ADD, OUT, CLASS.
- IDLE:
  - On in_valid & frame_start_in: clear accumulators, set idx=0, issue rom_addr=0 with rom_en=1, go to ACCUM.
  - Samples without frame_start are ignored.
- ACCUM:
  - Each in_valid sample issues rom_addr=idx and registers the sample.
  - One cycle later, for every k: acc[k] += (sample*w[k]) >>> FRAC_BITS. The product is full 2*DW signed; the shift is arithmetic; accumulation wraps at ACC_W bits.
  - in_valid gaps are allowed; rom_en=0 in gap cycles.
- Frame end:
  - in_valid & frame_end_in with idx==N_IN-1: go to BIAS_RD.
  - Any other idx: pulse err, go to IDLE, produce no output.
  - frame_start_in during ACCUM: pulse err, then restart the frame with that sample as index 0.
  - A sample at idx==N_IN-1 without frame_end_in: err, back to IDLE.
- BIAS_RD: rom_addr=N_IN, rom_en=1.
- BIAS_ADD: acc[k] += sign-extended b[k] << 0 (the bias is already in DW format). Then each acc saturates to DW: above 2^(DW-1)-1 → 0x7FFF; below -2^(DW-1) → 0x8000.
- OUT:
  - Emit N_OUT consecutive cycles of out_valid with logit k on cycle k.
  - frame_start_out with k=0; frame_end_out with k=N_OUT-1.
  - Running argmax uses strict greater-than, so on ties the lowest index wins.
- CLASS: class_valid=1 and class_idx for 1 cycle, then IDLE.
- Latency: with the frame_end_in sample in cycle T, the first out_valid is at T+4 and class_valid is at T+4+N_OUT.
- Input arriving while not in IDLE/ACCUM (BIAS_*/OUT/CLASS) is dropped and err pulses once per dropped sample. The upstream stage guarantees a frame gap ≥ N_OUT+4 cycles.

Decomposition:
- Shared package dense2_pkg: N_IN, N_OUT, DW, FRAC_BITS, ACC_W, saturation constants, FSM state encoding.
- One sub-module dense2_neuron_acc (per-neuron MAC + bias add + saturate), instantiated N_OUT times by generate.
- The FSM, counter, serializer and argmax stay in the top.

Test Plan:
- Inputs all 0x0100, w[k]=k*0x0010 for every row, biases 0 → logits k*0x0780 (k=9 → 0x4380), class_idx=9, first out_valid exactly 4 cycles after frame_end_in.
- Saturation:
  - Inputs 0x7FFF, weights 0x7FFF → all logits 0x7FFF.
  - Weights 0x8001 → all logits 0x8000.
  - class_idx=0 (tie).
- Bias only: inputs 0, biases k=3 → 0x0500, others 0xFF00 → logits match biases, class_idx=3.
- Irregular in_valid (random 0-3 idle cycles between samples) → logits/class identical to the back-to-back run of test 1.
- Short frame (frame_end_in on sample 50) → err pulse, no out_valid/class_valid; the following correct frame yields test-1 results.
- rst asserted for 1 cycle at sample 60 → all outputs 0 next cycle, no output for the aborted frame; the next frame is correct.

Source files
------------

// File: rtl/dense2_pkg.sv
// Shared constants, FSM encoding and saturation helper for the dense-2 / argmax classifier.
package dense2_pkg;

  localparam int unsigned N_IN      = 120;
  localparam int unsigned N_OUT     = 10;
  localparam int unsigned DW        = 16;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned AW        = 7;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PW        = 2 * DW;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS_RD,
    S_BIAS_ADD,
    S_OUT,
    S_CLASS
  } state_t;

  // Clamp a wide signed accumulator into the DW-bit logit range.
  function automatic logic [DW-1:0] saturate(input logic [ACC_W-1:0] v);
    logic fits;
    fits = (v[ACC_W-1:DW-1] == {(ACC_W-DW+1){v[ACC_W-1]}});
    if (fits) begin
      return v[DW-1:0];
    end
    return v[ACC_W-1] ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/dense2_neuron_acc.sv
// One output neuron: fixed-point MAC over the frame, then bias add with saturation to DW.
module dense2_neuron_acc
  import dense2_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          mac_en,
  input  logic          bias_en,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] weight,
  input  logic [DW-1:0] bias,
  output logic [DW-1:0] logit
);

  logic signed [PW-1:0] sample_x;
  logic signed [PW-1:0] weight_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     mac_term;
  logic [ACC_W-1:0]     bias_sum;

  // Full-width signed product, rescaled back to the activation's fixed-point grid.
  assign sample_x = PW'($signed(sample));
  assign weight_x = PW'($signed(weight));
  assign prod     = sample_x * weight_x;
  assign prod_sh  = prod >>> FRAC_BITS;
  assign mac_term = ACC_W'(prod_sh);
  assign bias_sum = acc + ACC_W'($signed(bias));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= acc + mac_term;
    end else if (bias_en) begin
      acc <= bias_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      logit <= '0;
    end else if (bias_en) begin
      logit <= saturate(bias_sum);
    end
  end

endmodule

// File: rtl/dense2_argmax.sv
// Dense-2 layer top: frame FSM, weight ROM addressing, N_OUT parallel neurons,
// logit serializer and running argmax. rom_en/rom_addr are combinational so the
// ROM's one-cycle latency lines up with the registered sample.
module dense2_argmax
  import dense2_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                frame_start_in,
  input  logic                frame_end_in,
  input  logic [DW-1:0]       dense_input,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic [N_OUT*DW-1:0] rom_data,
  output logic                out_valid,
  output logic                frame_start_out,
  output logic                frame_end_out,
  output logic [DW-1:0]       logit_out,
  output logic                class_valid,
  output logic [IDX_W-1:0]    class_idx,
  output logic                err
);

  state_t            state;
  state_t            state_n;
  logic [AW-1:0]     cnt;
  logic [AW-1:0]     cnt_n;
  logic              clear;
  logic              take;
  logic              err_c;
  logic              bias_en;
  logic              mac_q;
  logic [DW-1:0]     sample_q;
  logic [IDX_W-1:0]  out_k;
  logic [DW-1:0]     best_val;
  logic [IDX_W-1:0]  best_idx;
  logic [DW-1:0]     logits [N_OUT];

  assign bias_en = (state == S_BIAS_ADD);

  for (genvar k = 0; k < N_OUT; k++) begin : g_neuron
    dense2_neuron_acc u_acc (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .mac_en  (mac_q),
      .bias_en (bias_en),
      .sample  (sample_q),
      .weight  (rom_data[k*DW +: DW]),
      .bias    (rom_data[k*DW +: DW]),
      .logit   (logits[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, ROM request and frame-protocol checking.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rom_en   = 1'b0;
    rom_addr = '0;
    clear    = 1'b0;
    take     = 1'b0;
    err_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && frame_start_in) begin
          if (frame_end_in) begin
            err_c = 1'b1;
          end else begin
            clear    = 1'b1;
            take     = 1'b1;
            rom_en   = 1'b1;
            cnt_n    = AW'(1);
            state_n  = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          take   = 1'b1;
          rom_en = 1'b1;
          if (frame_start_in) begin
            // A new frame start mid-frame restarts accumulation with this sample.
            err_c = 1'b1;
            clear = 1'b1;
            cnt_n = AW'(1);
          end else begin
            rom_addr = cnt;
            if (frame_end_in) begin
              if (cnt == AW'(N_IN - 1)) begin
                state_n = S_BIAS_RD;
              end else begin
                err_c   = 1'b1;
                state_n = S_IDLE;
              end
            end else if (cnt == AW'(N_IN - 1)) begin
              err_c   = 1'b1;
              state_n = S_IDLE;
            end else begin
              cnt_n = cnt + AW'(1);
            end
          end
        end
      end
      S_BIAS_RD: begin
        rom_en   = 1'b1;
        rom_addr = AW'(N_IN);
        err_c    = in_valid;
        state_n  = S_BIAS_ADD;
      end
      S_BIAS_ADD: begin
        err_c   = in_valid;
        state_n = S_OUT;
      end
      S_OUT: begin
        err_c = in_valid;
        if (out_k == IDX_W'(N_OUT - 1)) begin
          state_n = S_CLASS;
        end
      end
      S_CLASS: begin
        err_c   = in_valid;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (rst) begin
      rom_en   = 1'b0;
      rom_addr = '0;
    end
  end

  // Sample pipeline, logit serializer and running argmax (lowest index wins ties).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      mac_q           <= 1'b0;
      sample_q        <= '0;
      out_k           <= '0;
      best_val        <= '0;
      best_idx        <= '0;
      out_valid       <= 1'b0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      logit_out       <= '0;
      class_valid     <= 1'b0;
      class_idx       <= '0;
      err             <= 1'b0;
    end else begin
      cnt             <= cnt_n;
      mac_q           <= take;
      err             <= err_c;
      out_valid       <= 1'b0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      class_valid     <= 1'b0;
      if (take) begin
        sample_q <= dense_input;
      end
      case (state)
        S_BIAS_ADD: begin
          out_k <= '0;
        end
        S_OUT: begin
          out_valid       <= 1'b1;
          logit_out       <= logits[out_k];
          frame_start_out <= (out_k == '0);
          frame_end_out   <= (out_k == IDX_W'(N_OUT - 1));
          out_k           <= out_k + IDX_W'(1);
          if ((out_k == '0) || ($signed(logits[out_k]) > $signed(best_val))) begin
            best_val <= logits[out_k];
            best_idx <= out_k;
          end
        end
        S_CLASS: begin
          class_valid <= 1'b1;
          class_idx   <= best_idx;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense2_argmax.sv
// Self-checking bench for dense2_argmax: ROM model, output monitor and an
// integer-arithmetic reference of the layer.
module tb_dense2_argmax;
  import dense2_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                frame_start_in = 1'b0;
  logic                frame_end_in = 1'b0;
  logic [DW-1:0]       dense_input = '0;
  logic                rom_en;
  logic [AW-1:0]       rom_addr;
  logic [N_OUT*DW-1:0] rom_data = '0;
  logic                out_valid;
  logic                frame_start_out;
  logic                frame_end_out;
  logic [DW-1:0]       logit_out;
  logic                class_valid;
  logic [IDX_W-1:0]    class_idx;
  logic                err;

  dense2_argmax dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .frame_start_in  (frame_start_in),
    .frame_end_in    (frame_end_in),
    .dense_input     (dense_input),
    .rom_en          (rom_en),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .out_valid       (out_valid),
    .frame_start_out (frame_start_out),
    .frame_end_out   (frame_end_out),
    .logit_out       (logit_out),
    .class_valid     (class_valid),
    .class_idx       (class_idx),
    .err             (err)
  );

  always #5 clk = ~clk;

  int xin [N_IN];
  int wt  [N_IN+1][N_OUT];
  int exp_logit [N_OUT];
  int exp_class;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] got_logit [$];
  int            got_cyc   [$];
  logic          got_fs    [$];
  logic          got_fe    [$];
  int            cls_val   [$];
  int            cls_cyc   [$];
  int            err_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight/bias ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (rom_en && (rom_addr <= AW'(N_IN))) begin
      for (int k = 0; k < N_OUT; k++) rom_data[k*DW +: DW] <= DW'(wt[rom_addr][k]);
    end
  end

  always @(negedge clk) begin
    if (out_valid) begin
      got_logit.push_back(logit_out);
      got_cyc.push_back(cyc);
      got_fs.push_back(frame_start_out);
      got_fe.push_back(frame_end_out);
    end
    if (class_valid) begin
      cls_val.push_back(int'(class_idx));
      cls_cyc.push_back(cyc);
    end
    if (err) err_n++;
  end

  // Reference: integer MAC with arithmetic rescale, bias, clamp, first-max argmax.
  function automatic void compute_model();
    int acc;
    int best;
    for (int k = 0; k < N_OUT; k++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += (xin[i] * wt[i][k]) >>> FRAC_BITS;
      acc += wt[N_IN][k];
      if (acc > 32767) exp_logit[k] = 32767;
      else if (acc < -32768) exp_logit[k] = -32768;
      else exp_logit[k] = acc;
    end
    best = 0;
    for (int k = 1; k < N_OUT; k++) if (exp_logit[k] > exp_logit[best]) best = k;
    exp_class = best;
  endfunction

  function automatic void load_ramp();
    for (int i = 0; i < N_IN; i++) xin[i] = 256;
    for (int i = 0; i <= N_IN; i++)
      for (int k = 0; k < N_OUT; k++) wt[i][k] = (i == N_IN) ? 0 : k * 16;
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic clear_mon();
    got_logit.delete(); got_cyc.delete(); got_fs.delete(); got_fe.delete();
    cls_val.delete(); cls_cyc.delete();
    err_n = 0;
  endtask

  task automatic send_frame(input int n, input int gap_max, input int rst_at, output int t_end);
    t_end = 0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0 && i > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        @(posedge clk); #1;
        in_valid = 1'b0; frame_start_in = 1'b0; frame_end_in = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      frame_start_in = (i == 0);
      frame_end_in = (i == n - 1);
      dense_input = DW'(xin[i]);
      t_end = cyc;
      if (i == rst_at) begin
        rst = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start_in = 1'b0; frame_end_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({out_valid, frame_start_out, frame_end_out, logit_out, class_valid, class_idx, err, rom_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b lg=%h cv=%b ci=%0d err=%b rom_en=%b, want all 0",
               out_valid, logit_out, class_valid, class_idx, err, rom_en);
    end
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; dense_input = 16'h0100;
      #1;
      n_checks++;
      if (rom_en !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_start_rom_en: got %b, want 0", rom_en);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    n_checks++;
    if (got_logit.size() != 0 || cls_val.size() != 0 || err_n != 0) begin
      n_fail++;
      $display("FAIL idle_ignore: got %0d logits %0d classes %0d errs, want 0 0 0",
               got_logit.size(), cls_val.size(), err_n);
    end
  endtask

  task automatic test_basic();
    int t_end;
    load_ramp(); compute_model(); clear_mon();
    send_frame(N_IN, 0, -1, t_end);
    repeat (20) @(posedge clk);
    n_checks++;
    if (got_logit.size() != N_OUT) begin
      n_fail++;
      $display("FAIL basic_count: got %0d logits, want %0d", got_logit.size(), N_OUT);
    end
    for (int k = 0; k < N_OUT && k < got_logit.size(); k++) begin
      n_checks++;
      if ({got_logit[k], got_fs[k], got_fe[k]} !== {16'(k * 16'h0780), k == 0, k == N_OUT - 1}) begin
        n_fail++;
        $display("FAIL basic_logit[%0d]: got %h fs=%b fe=%b, want %h fs=%b fe=%b", k, got_logit[k],
                 got_fs[k], got_fe[k], 16'(k * 16'h0780), k == 0, k == N_OUT - 1);
      end
      n_checks++;
      if (got_cyc[k] != t_end + 4 + k) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got cycle %0d, want %0d", k, got_cyc[k], t_end + 4 + k);
      end
    end
    n_checks++;
    if (cls_val.size() != 1 || cls_val[0] != 9 || cls_cyc[0] != t_end + 4 + N_OUT || err_n != 0) begin
      n_fail++;
      $display("FAIL basic_class: got n=%0d idx=%0d cyc=%0d errs=%0d, want n=1 idx=9 cyc=%0d errs=0",
               cls_val.size(), cls_val.size() ? cls_val[0] : -1, cls_cyc.size() ? cls_cyc[0] : -1,
               err_n, t_end + 4 + N_OUT);
    end
  endtask

  task automatic test_saturation();
    int t_end;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N_IN; i++) xin[i] = 32767;
      for (int i = 0; i <= N_IN; i++)
        for (int k = 0; k < N_OUT; k++) wt[i][k] = (i == N_IN) ? 0 : (pass == 0 ? 32767 : -32767);
      compute_model(); clear_mon();
      send_frame(N_IN, 0, -1, t_end);
      repeat (20) @(posedge clk);
      n_checks++;
      if (got_logit.size() != N_OUT) begin
        n_fail++;
        $display("FAIL sat%0d_count: got %0d, want %0d", pass, got_logit.size(), N_OUT);
      end
      for (int k = 0; k < N_OUT && k < got_logit.size(); k++) begin
        n_checks++;
        if (got_logit[k] !== (pass == 0 ? 16'h7FFF : 16'h8000)) begin
          n_fail++;
          $display("FAIL sat%0d_logit[%0d]: got %h, want %h", pass, k, got_logit[k],
                   pass == 0 ? 16'h7FFF : 16'h8000);
        end
      end
      n_checks++;
      if (cls_val.size() != 1 || cls_val[0] != 0) begin
        n_fail++;
        $display("FAIL sat%0d_class: got n=%0d idx=%0d, want n=1 idx=0", pass, cls_val.size(),
                 cls_val.size() ? cls_val[0] : -1);
      end
    end
  endtask

  task automatic test_bias_only();
    int t_end;
    for (int i = 0; i < N_IN; i++) xin[i] = 0;
    for (int i = 0; i < N_IN; i++) for (int k = 0; k < N_OUT; k++) wt[i][k] = rnd16();
    for (int k = 0; k < N_OUT; k++) wt[N_IN][k] = (k == 3) ? 16'sh0500 : -256;
    compute_model(); clear_mon();
    send_frame(N_IN, 0, -1, t_end);
    repeat (20) @(posedge clk);
    n_checks++;
    if (got_logit.size() != N_OUT) begin
      n_fail++;
      $display("FAIL bias_count: got %0d, want %0d", got_logit.size(), N_OUT);
    end
    for (int k = 0; k < N_OUT && k < got_logit.size(); k++) begin
      n_checks++;
      if (got_logit[k] !== ((k == 3) ? 16'h0500 : 16'hFF00)) begin
        n_fail++;
        $display("FAIL bias_logit[%0d]: got %h, want %h", k, got_logit[k], (k == 3) ? 16'h0500 : 16'hFF00);
      end
    end
    n_checks++;
    if (cls_val.size() != 1 || cls_val[0] != 3) begin
      n_fail++;
      $display("FAIL bias_class: got n=%0d idx=%0d, want n=1 idx=3", cls_val.size(),
               cls_val.size() ? cls_val[0] : -1);
    end
  endtask

  task automatic test_irregular();
    int t_end;
    load_ramp(); compute_model(); clear_mon();
    send_frame(N_IN, 3, -1, t_end);
    repeat (20) @(posedge clk);
    n_checks++;
    if (got_logit.size() != N_OUT) begin
      n_fail++;
      $display("FAIL irregular_count: got %0d, want %0d", got_logit.size(), N_OUT);
    end
    for (int k = 0; k < N_OUT && k < got_logit.size(); k++) begin
      n_checks++;
      if (got_logit[k] !== 16'(exp_logit[k]) || got_cyc[k] != t_end + 4 + k) begin
        n_fail++;
        $display("FAIL irregular_logit[%0d]: got %h @%0d, want %h @%0d", k, got_logit[k], got_cyc[k],
                 16'(exp_logit[k]), t_end + 4 + k);
      end
    end
    n_checks++;
    if (cls_val.size() != 1 || cls_val[0] != exp_class) begin
      n_fail++;
      $display("FAIL irregular_class: got n=%0d idx=%0d, want n=1 idx=%0d", cls_val.size(),
               cls_val.size() ? cls_val[0] : -1, exp_class);
    end
  endtask

  task automatic test_short_frame();
    int t_end;
    load_ramp(); compute_model(); clear_mon();
    send_frame(51, 0, -1, t_end);
    repeat (20) @(posedge clk);
    n_checks++;
    if (err_n != 1 || got_logit.size() != 0 || cls_val.size() != 0) begin
      n_fail++;
      $display("FAIL short_frame: got errs=%0d logits=%0d classes=%0d, want 1 0 0",
               err_n, got_logit.size(), cls_val.size());
    end
  endtask

  task automatic test_reset_mid();
    int t_end;
    load_ramp(); compute_model(); clear_mon();
    send_frame(N_IN, 0, 60, t_end);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; frame_start_in = 1'b0; frame_end_in = 1'b0;
    n_checks++;
    if ({out_valid, frame_start_out, frame_end_out, logit_out, class_valid, class_idx, err, rom_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got ov=%b lg=%h cv=%b ci=%0d err=%b rom_en=%b, want all 0",
               out_valid, logit_out, class_valid, class_idx, err, rom_en);
    end
    repeat (20) @(posedge clk);
    n_checks++;
    if (err_n != 0 || got_logit.size() != 0 || cls_val.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got errs=%0d logits=%0d classes=%0d, want 0 0 0",
               err_n, got_logit.size(), cls_val.size());
    end
  endtask

  // Random data back to back, plus samples injected while logits are streaming out.
  task automatic test_back_to_back();
    int t_end;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N_IN; i++) xin[i] = rnd16();
      for (int i = 0; i <= N_IN; i++) for (int k = 0; k < N_OUT; k++) wt[i][k] = rnd16();
      compute_model(); clear_mon();
      send_frame(N_IN, (f == 1) ? 2 : 0, -1, t_end);
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        in_valid = 1'b1; dense_input = DW'(rnd16());
      end
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      n_checks++;
      if (got_logit.size() != N_OUT || err_n != 3) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d logits %0d errs, want %0d logits 3 errs",
                 f, got_logit.size(), err_n, N_OUT);
      end
      for (int k = 0; k < N_OUT && k < got_logit.size(); k++) begin
        n_checks++;
        if (got_logit[k] !== 16'(exp_logit[k])) begin
          n_fail++;
          $display("FAIL rand%0d_logit[%0d]: got %h, want %h", f, k, got_logit[k], 16'(exp_logit[k]));
        end
      end
      n_checks++;
      if (cls_val.size() != 1 || cls_val[0] != exp_class) begin
        n_fail++;
        $display("FAIL rand%0d_class: got n=%0d idx=%0d, want n=1 idx=%0d", f, cls_val.size(),
                 cls_val.size() ? cls_val[0] : -1, exp_class);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_bias_only();
    test_irregular();
    test_short_frame();
    test_basic();
    test_reset_mid();
    test_basic();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
